imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//  Shares the single-ported, word-organised instruction memory between the core fetch path and a loader/debug port.
//  Arbitrates one access per cycle, drives the memory port, and routes the 1-cycle-latency read data back to its owner.
//  Sits between the fetch stage / boot loader and the instruction memory macro.
// PARAMETERS
//  DEPTH         32  memory depth in 32-bit words; word index = addr[31:2]
//  STARVE_LIMIT  3   consecutive denied loader cycles before the loader is forced ahead of fetch
//  OOR_DATA      32'h00000013  read data returned for out-of-range reads (NOP)
// PORTS
//  clk_i          in   1   clock; all state updates on rising edge
//  reset_i        in   1   synchronous, active-high reset
//  fetch_req_i    in   1   fetch read request
//  fetch_addr_i   in   32  fetch byte address
//  fetch_gnt_o    out  1   fetch request accepted this cycle (combinational)
//  fetch_rvalid_o out  1   fetch read data valid (registered)
//  fetch_rdata_o  out  32  fetch read data
//  ldr_req_i      in   1   loader request
//  ldr_we_i       in   1   1 = write, 0 = read
//  ldr_addr_i     in   32  loader byte address
//  ldr_wdata_i    in   32  loader write data
//  ldr_gnt_o      out  1   loader request accepted this cycle (combinational)
//  ldr_rvalid_o   out  1   loader read data valid (registered)
//  ldr_rdata_o    out  32  loader read data
//  mem_en_o       out  1   memory access strobe
//  mem_we_o       out  1   memory write enable
//  mem_addr_o     out  5   memory word index, width $clog2(DEPTH)
//  mem_wdata_o    out  32  memory write data
//  mem_rdata_i    in   32  memory read data, valid the cycle after mem_en_o=1 and mem_we_o=0
//  oor_err_o      out  1   1-cycle pulse when an out-of-range request is accepted
// BEHAVIOUR
//  - Handshake: a request is accepted when req & gnt in the same cycle. The requester must hold req/addr/data until gnt.
//    At most one gnt per cycle, and gnt is never asserted without req.
//  - Arbitration FSM:
//    - NORMAL: fetch wins whenever fetch_req_i=1; the loader is granted only when fetch_req_i=0.
//    - starve_cnt increments each cycle ldr_req_i=1 and the loader is denied; it clears to 0 on a loader grant or when ldr_req_i=0.
//    - starve_cnt==STARVE_LIMIT -> FORCE.
//    - FORCE: the loader is granted unconditionally (fetch denied) for exactly one cycle, then -> NORMAL with starve_cnt=0.
//    - If ldr_req_i has dropped by then, FORCE still exits to NORMAL and fetch may be granted that cycle.
//  - Memory drive: on an accepted in-range request, mem_en_o=1 and mem_addr_o=addr[31:2] in the same cycle (0 latency).
//    mem_we_o=ldr_we_i for the loader and 0 for fetch; mem_wdata_o=ldr_wdata_i.
//    With no accepted request, mem_en_o=0 and mem_we_o=0.
//  - Read return: resp_pend_q/resp_owner_q are registered at acceptance.
//    Exactly one cycle later, the owner's rvalid=1 and its rdata=mem_rdata_i. The other owner's rvalid stays 0.
//    rdata outputs hold their last value when rvalid=0.
//    Back-to-back reads are fully pipelined: one response per cycle.
//  - Writes produce no rvalid.
//  - Out of range (addr[31:2] >= DEPTH):
//    - The request is still granted, mem_en_o stays 0, and oor_err_o pulses in the acceptance cycle.
//    - A read returns rvalid the next cycle with rdata=OOR_DATA.
//    - A write is dropped.
//  - Misaligned addresses (addr[1:0]!=0): the low bits are ignored.
//  - Reset (any cycle, including mid-access):
//    - All gnt, rvalid, mem_en_o, mem_we_o and oor_err_o are 0; rdata outputs, mem_addr_o and mem_wdata_o are 0.
//    - FSM=NORMAL, starve_cnt=0, any pending response is discarded (no rvalid in the cycle after reset).
//    - gnt outputs are forced 0 while reset_i=1.
// TESTING
//  1. Reset, then fetch_req=1 addr=0x4 for 1 cycle -> same cycle fetch_gnt=1, mem_en=1, mem_addr=1; next cycle fetch_rvalid=1, fetch_rdata=mem[1].
//  2. Loader write addr=0x8 data=0xDEADBEEF, then fetch read 0x8 -> mem_we=1 in the write cycle; the fetch read returns 0xDEADBEEF.
//  3. fetch_req and ldr_req both held high from cycle 0 (STARVE_LIMIT=3) -> fetch granted cycles 0-2, loader granted cycle 3, fetch granted cycle 4.
//  4. Fetch read addr=0x80 (DEPTH=32) -> gnt=1, mem_en=0, oor_err=1 that cycle; next cycle fetch_rvalid=1, rdata=0x00000013.
//  5. Fetch read accepted in cycle N, reset_i=1 in cycle N+1 -> fetch_rvalid=0 in N+1 and N+2, all outputs 0, and starve_cnt cleared.
//  6. Alternating fetch read / loader read every cycle -> each rvalid lands on the correct owner one cycle after its grant, with no cross-routing.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: arbitrates fetch and loader accesses to a single-ported instruction memory
module imem_port_arbiter #(
   parameter int          DEPTH        = 32,
   parameter int          STARVE_LIMIT = 3,
   parameter logic [31:0] OOR_DATA     = 32'h00000013
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     fetch_req_i,
   input  logic [31:0]              fetch_addr_i,
   output logic                     fetch_gnt_o,
   output logic                     fetch_rvalid_o,
   output logic [31:0]              fetch_rdata_o,
   input  logic                     ldr_req_i,
   input  logic                     ldr_we_i,
   input  logic [31:0]              ldr_addr_i,
   input  logic [31:0]              ldr_wdata_i,
   output logic                     ldr_gnt_o,
   output logic                     ldr_rvalid_o,
   output logic [31:0]              ldr_rdata_o,
   output logic                     mem_en_o,
   output logic                     mem_we_o,
   output logic [$clog2(DEPTH)-1:0] mem_addr_o,
   output logic [31:0]              mem_wdata_o,
   input  logic [31:0]              mem_rdata_i,
   output logic                     oor_err_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   typedef enum logic {NORMAL, FORCE} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] starve_q, starve_d;
   logic [31:0]   sel_addr, rdata_now, fetch_rdata_q, ldr_rdata_q;
   logic          acc, in_range, resp_pend_q, resp_owner_q, resp_oor_q;
   logic          unused_low_bits;
   // grant selection and starvation tracking; nothing is granted while in reset
   always_comb begin
      fetch_gnt_o = 1'b0;
      ldr_gnt_o   = 1'b0;
      starve_d    = '0;
      state_d     = NORMAL;
      if (!reset_i && state_q == FORCE) begin
         ldr_gnt_o   = ldr_req_i;
         fetch_gnt_o = fetch_req_i & ~ldr_req_i;
      end else if (!reset_i) begin
         fetch_gnt_o = fetch_req_i;
         ldr_gnt_o   = ldr_req_i & ~fetch_req_i;
         starve_d    = (ldr_req_i && !ldr_gnt_o) ? starve_q + 1'b1 : '0;
         state_d     = (starve_d == CW'(STARVE_LIMIT)) ? FORCE : NORMAL;
      end
   end
   // arbitration state register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= NORMAL;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end
   assign acc             = fetch_gnt_o | ldr_gnt_o;
   assign sel_addr        = ldr_gnt_o ? ldr_addr_i : fetch_addr_i;
   assign in_range        = {2'b00, sel_addr[31:2]} < 32'(DEPTH);
   assign unused_low_bits = ^sel_addr[1:0];
   assign mem_en_o        = acc & in_range;
   assign mem_we_o        = mem_en_o & ldr_gnt_o & ldr_we_i;
   assign mem_addr_o      = mem_en_o ? sel_addr[AW+1:2] : '0;
   assign mem_wdata_o     = reset_i ? '0 : ldr_wdata_i;
   assign oor_err_o       = acc & ~in_range;
   // remember who owns the read in flight and hold the last delivered data per owner
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         resp_pend_q   <= 1'b0;
         resp_owner_q  <= 1'b0;
         resp_oor_q    <= 1'b0;
         fetch_rdata_q <= '0;
         ldr_rdata_q   <= '0;
      end else begin
         resp_pend_q   <= acc & ~(ldr_gnt_o & ldr_we_i);
         resp_owner_q  <= ldr_gnt_o;
         resp_oor_q    <= ~in_range;
         fetch_rdata_q <= fetch_rvalid_o ? rdata_now : fetch_rdata_q;
         ldr_rdata_q   <= ldr_rvalid_o ? rdata_now : ldr_rdata_q;
      end
   end
   assign rdata_now      = resp_oor_q ? OOR_DATA : mem_rdata_i;
   assign fetch_rvalid_o = ~reset_i & resp_pend_q & ~resp_owner_q;
   assign ldr_rvalid_o   = ~reset_i & resp_pend_q & resp_owner_q;
   assign fetch_rdata_o  = reset_i ? '0 : fetch_rvalid_o ? rdata_now : fetch_rdata_q;
   assign ldr_rdata_o    = reset_i ? '0 : ldr_rvalid_o ? rdata_now : ldr_rdata_q;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed checks of the instruction memory port arbiter
module tb_imem_port_arbiter;
   logic        clk_i = 1'b0, reset_i = 1'b1;
   logic        fetch_req_i = 1'b0, ldr_req_i = 1'b0, ldr_we_i = 1'b0;
   logic [31:0] fetch_addr_i = '0, ldr_addr_i = '0, ldr_wdata_i = '0, mem_rdata_i = '0;
   logic        fetch_gnt_o, fetch_rvalid_o, ldr_gnt_o, ldr_rvalid_o;
   logic        mem_en_o, mem_we_o, oor_err_o;
   logic [31:0] fetch_rdata_o, ldr_rdata_o, mem_wdata_o;
   logic [4:0]  mem_addr_o;
   logic [31:0] mem [32];
   int          n_tests = 0, n_fail = 0;

   imem_port_arbiter dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_gnt_o(fetch_gnt_o),
      .fetch_rvalid_o(fetch_rvalid_o), .fetch_rdata_o(fetch_rdata_o),
      .ldr_req_i(ldr_req_i), .ldr_we_i(ldr_we_i), .ldr_addr_i(ldr_addr_i), .ldr_wdata_i(ldr_wdata_i),
      .ldr_gnt_o(ldr_gnt_o), .ldr_rvalid_o(ldr_rvalid_o), .ldr_rdata_o(ldr_rdata_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .oor_err_o(oor_err_o)
   );

   always #5 clk_i = ~clk_i;

   // memory macro: word i holds 0x10000000+i after reset, 1-cycle read latency
   always @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'h10000000 + 32'(i);
      end else if (mem_en_o && mem_we_o) begin
         mem[mem_addr_o] <= mem_wdata_o;
      end
      mem_rdata_i <= (mem_en_o && !mem_we_o) ? mem[mem_addr_o] : 32'hBAD0BAD0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // reset with fetch requesting: grants must stay low
      fetch_req_i = 1'b1;
      cyc();
      cyc();
      #1;
      chk("rst_fetch_gnt", fetch_gnt_o, 0);
      chk("rst_mem_en", mem_en_o, 0);
      chk("rst_fetch_rvalid", fetch_rvalid_o, 0);
      chk("rst_fetch_rdata", fetch_rdata_o, 0);
      chk("rst_mem_wdata", mem_wdata_o, 0);
      cyc();
      // basic fetch read of word 1
      reset_i = 1'b0;
      fetch_addr_i = 32'h4;
      #1;
      chk("t1_gnt", fetch_gnt_o, 1);
      chk("t1_ldr_gnt", ldr_gnt_o, 0);
      chk("t1_mem_en", mem_en_o, 1);
      chk("t1_mem_we", mem_we_o, 0);
      chk("t1_mem_addr", mem_addr_o, 1);
      cyc();
      fetch_req_i = 1'b0;
      #1;
      chk("t1_rvalid", fetch_rvalid_o, 1);
      chk("t1_rdata", fetch_rdata_o, 32'h10000001);
      chk("t1_ldr_rvalid", ldr_rvalid_o, 0);
      cyc();
      #1;
      chk("t1_rvalid_idle", fetch_rvalid_o, 0);
      chk("t1_rdata_hold", fetch_rdata_o, 32'h10000001);
      // loader write then fetch readback
      ldr_req_i = 1'b1; ldr_we_i = 1'b1; ldr_addr_i = 32'h8; ldr_wdata_i = 32'hDEADBEEF;
      #1;
      chk("t2_ldr_gnt", ldr_gnt_o, 1);
      chk("t2_mem_we", mem_we_o, 1);
      chk("t2_mem_addr", mem_addr_o, 2);
      chk("t2_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
      cyc();
      ldr_req_i = 1'b0; ldr_we_i = 1'b0;
      fetch_req_i = 1'b1; fetch_addr_i = 32'h8;
      #1;
      chk("t2_wr_no_rvalid", ldr_rvalid_o, 0);
      chk("t2_fetch_gnt", fetch_gnt_o, 1);
      cyc();
      fetch_req_i = 1'b0;
      #1;
      chk("t2_rvalid", fetch_rvalid_o, 1);
      chk("t2_rdata", fetch_rdata_o, 32'hDEADBEEF);
      cyc();
      // starvation: both requesting; loader forced ahead on the fourth cycle
      fetch_req_i = 1'b1; fetch_addr_i = 32'hC;
      ldr_req_i = 1'b1; ldr_addr_i = 32'h10;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("t3_fetch_gnt_c%0d", k), fetch_gnt_o, (k == 3) ? 0 : 1);
         chk($sformatf("t3_ldr_gnt_c%0d", k), ldr_gnt_o, (k == 3) ? 1 : 0);
         if (k == 3) chk("t3_fetch_rvalid_c3", fetch_rvalid_o, 1);
         if (k == 4) chk("t3_ldr_rvalid_c4", ldr_rvalid_o, 1);
         if (k == 4) chk("t3_ldr_rdata_c4", ldr_rdata_o, 32'h10000004);
         if (k == 4) chk("t3_fetch_rvalid_c4", fetch_rvalid_o, 0);
         cyc();
      end
      fetch_req_i = 1'b0; ldr_req_i = 1'b0;
      #1;
      chk("t3_fetch_rvalid_after", fetch_rvalid_o, 1);
      chk("t3_fetch_rdata_after", fetch_rdata_o, 32'h10000003);
      cyc();
      // out-of-range fetch read
      fetch_req_i = 1'b1; fetch_addr_i = 32'h80;
      #1;
      chk("t4_gnt", fetch_gnt_o, 1);
      chk("t4_mem_en", mem_en_o, 0);
      chk("t4_oor", oor_err_o, 1);
      cyc();
      fetch_req_i = 1'b0;
      #1;
      chk("t4_rvalid", fetch_rvalid_o, 1);
      chk("t4_rdata", fetch_rdata_o, 32'h00000013);
      chk("t4_oor_clear", oor_err_o, 0);
      cyc();
      // out-of-range loader write is dropped
      ldr_req_i = 1'b1; ldr_we_i = 1'b1; ldr_addr_i = 32'h84; ldr_wdata_i = 32'h12345678;
      #1;
      chk("t4w_gnt", ldr_gnt_o, 1);
      chk("t4w_mem_en", mem_en_o, 0);
      chk("t4w_mem_we", mem_we_o, 0);
      chk("t4w_oor", oor_err_o, 1);
      cyc();
      ldr_req_i = 1'b0; ldr_we_i = 1'b0;
      // last in-range word and misaligned address
      fetch_req_i = 1'b1; fetch_addr_i = 32'h7C;
      #1;
      chk("t4w_no_rvalid", ldr_rvalid_o, 0);
      chk("edge_mem_en", mem_en_o, 1);
      chk("edge_mem_addr", mem_addr_o, 31);
      chk("edge_oor", oor_err_o, 0);
      cyc();
      fetch_addr_i = 32'h7;
      #1;
      chk("edge_rdata", fetch_rdata_o, 32'h1000001F);
      chk("misalign_addr", mem_addr_o, 1);
      cyc();
      fetch_req_i = 1'b0;
      cyc();
      // reset mid-access, with starvation counter part-way
      fetch_req_i = 1'b1; fetch_addr_i = 32'h4; ldr_req_i = 1'b1; ldr_addr_i = 32'h10;
      cyc();
      #1;
      chk("t5_pre_gnt", fetch_gnt_o, 1);
      cyc();
      reset_i = 1'b1;
      #1;
      chk("t5_rst_rvalid", fetch_rvalid_o, 0);
      chk("t5_rst_fetch_gnt", fetch_gnt_o, 0);
      chk("t5_rst_ldr_gnt", ldr_gnt_o, 0);
      chk("t5_rst_rdata", fetch_rdata_o, 0);
      chk("t5_rst_mem_en", mem_en_o, 0);
      chk("t5_rst_mem_addr", mem_addr_o, 0);
      cyc();
      reset_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (k == 0) chk("t5_post_rvalid", fetch_rvalid_o, 0);
         chk($sformatf("t5_fetch_gnt_c%0d", k), fetch_gnt_o, (k == 3) ? 0 : 1);
         chk($sformatf("t5_ldr_gnt_c%0d", k), ldr_gnt_o, (k == 3) ? 1 : 0);
         cyc();
      end
      fetch_req_i = 1'b0; ldr_req_i = 1'b0;
      cyc();
      cyc();
      // alternating fetch / loader reads of words 5..8
      for (int k = 0; k < 5; k++) begin
         fetch_req_i = (k < 4) && (k % 2 == 0);
         ldr_req_i = (k < 4) && (k % 2 == 1);
         fetch_addr_i = 32'(4 * (5 + k));
         ldr_addr_i = 32'(4 * (5 + k));
         #1;
         if (k < 4) chk($sformatf("t6_gnt_c%0d", k), {fetch_gnt_o, ldr_gnt_o}, (k % 2 == 0) ? 2 : 1);
         if (k > 0) chk($sformatf("t6_rvalid_c%0d", k), {fetch_rvalid_o, ldr_rvalid_o}, (k % 2 == 1) ? 2 : 1);
         if (k > 0) chk($sformatf("t6_rdata_c%0d", k), (k % 2 == 1) ? fetch_rdata_o : ldr_rdata_o, 32'h10000004 + 32'(k));
         cyc();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
